// File: rtl/led_fader.sv
`default_nettype none
// ============================================================================
//  Module   : led_fader
//  Purpose  : Per-LED brightness fader. Each channel ramps its level up
//             towards MAX while its input bit is high and down towards 0
//             while it is low. The level is rendered as PWM. With fading
//             disabled the level snaps to its target every cycle, giving a
//             registered on/off pass-through.
//  Revision : 1.0  initial release
// ============================================================================
module led_fader #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 4,
    parameter int FADE_DIV = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] leds_in,
    input  logic                fade_en,
    output logic [NUM_LEDS-1:0] leds_out,
    output logic                busy
);

    // Prescaler width: at least one bit, even when every cycle is a step.
    localparam int                c_fdw       = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] c_max     = {PWM_BITS{1'b1}};
    localparam logic [c_fdw-1:0]  c_fade_last = c_fdw'(FADE_DIV - 1);

    logic [NUM_LEDS-1:0] r_leds_q;
    logic                r_fen_q;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [c_fdw-1:0]    r_fade_cnt;
    logic [PWM_BITS-1:0] r_level [NUM_LEDS];
    logic [NUM_LEDS-1:0] r_leds_out;
    logic                r_busy;

    logic                w_fade_tick;
    logic [PWM_BITS-1:0] w_tgt       [NUM_LEDS];
    logic [PWM_BITS-1:0] w_level_nxt [NUM_LEDS];
    logic [NUM_LEDS-1:0] w_pwm_hi;
    logic [NUM_LEDS-1:0] w_diff;

    // One-cycle step strobe at the end of each prescaler period.
    assign w_fade_tick = (r_fade_cnt == c_fade_last);

    // Input capture plus the free-running PWM and prescaler counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds_q   <= '0;
            r_fen_q    <= 1'b0;
            r_pwm_cnt  <= '0;
            r_fade_cnt <= '0;
        end else begin
            r_leds_q   <= leds_in;
            r_fen_q    <= fade_en;
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            r_fade_cnt <= w_fade_tick ? '0 : r_fade_cnt + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
            assign w_tgt[gi] = r_leds_q[gi] ? c_max : '0;

            // Next level: snap to target when fading is off, otherwise one
            // saturating step towards the target on each fade tick. Direction
            // always follows the current input, so reversals continue from
            // wherever the ramp currently is.
            always_comb begin
                w_level_nxt[gi] = r_level[gi];
                if (!r_fen_q) begin
                    w_level_nxt[gi] = w_tgt[gi];
                end else if (w_fade_tick) begin
                    if (r_leds_q[gi] && (r_level[gi] != c_max)) begin
                        w_level_nxt[gi] = r_level[gi] + 1'b1;
                    end else if (!r_leds_q[gi] && (r_level[gi] != '0)) begin
                        w_level_nxt[gi] = r_level[gi] - 1'b1;
                    end
                end
            end

            // MAX is forced fully on; below that, level L is high for L
            // counter values out of every PWM period.
            assign w_pwm_hi[gi] = (r_level[gi] == c_max) || (r_level[gi] > r_pwm_cnt);
            assign w_diff[gi]   = (r_level[gi] != w_tgt[gi]);
        end
    endgenerate

    // Level registers for all channels.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (rst) begin
                r_level[i] <= '0;
            end else begin
                r_level[i] <= w_level_nxt[i];
            end
        end
    end

    // Registered LED drive and ramp-in-progress flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds_out <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_leds_out <= w_pwm_hi;
            r_busy     <= |w_diff;
        end
    end

    assign leds_out = r_leds_out;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_fader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_fader
//  Purpose  : Self-checking bench for led_fader (default instance plus a
//             slow-prescaler instance for PWM duty measurement).
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_fader;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] leds_in;
    logic       fade_en;
    logic [3:0] leds_out;
    logic       busy;

    logic       rst_b;
    logic [3:0] leds_in_b;
    logic       fade_en_b;
    logic [3:0] leds_out_b;
    logic       busy_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] leds;
        logic [3:0] exp_out;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    led_fader dut (
        .clk      (clk),
        .rst      (rst),
        .leds_in  (leds_in),
        .fade_en  (fade_en),
        .leds_out (leds_out),
        .busy     (busy)
    );

    led_fader #(.FADE_DIV(64)) dut_slow (
        .clk      (clk),
        .rst      (rst_b),
        .leds_in  (leds_in_b),
        .fade_en  (fade_en_b),
        .leds_out (leds_out_b),
        .busy     (busy_b)
    );

    // Advance one clock and sample shortly after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // leds_in[0] as driven after edge m of the main sequence (edge 0 is the
    // last reset edge; before it the input register holds its reset 0).
    function automatic int din(input int m);
        if (m < 0)   return 0;
        if (m < 40)  return 1;
        if (m < 56)  return 0;
        if (m < 90)  return 1;
        if (m < 140) return 0;
        return 1;
    endfunction

    // Hand-derived level[0] after edge m: steps land on even edges and use
    // the input captured one edge earlier.
    function automatic int lvl(input int m);
        int v;
        if (m <= 0)        v = 0;
        else if (m <= 40)  v = m / 2;
        else if (m <= 56)  v = 15 - (m - 40) / 2;
        else if (m <= 90)  v = 7 + (m - 56) / 2;
        else if (m <= 140) v = 15 - (m - 90) / 2;
        else               v = (m - 140) / 2;
        if (v > 15) v = 15;
        if (v < 0)  v = 0;
        return v;
    endfunction

    task automatic check_cycle(input int n);
        int l;
        int e0;
        int eb;
        l  = lvl(n - 1);
        e0 = ((l == 15) || (l > ((n - 1) % 16))) ? 1 : 0;
        eb = (l != ((din(n - 2) != 0) ? 15 : 0)) ? 1 : 0;
        chk($sformatf("ramp leds_out n=%0d", n), int'(leds_out), e0);
        chk($sformatf("ramp busy n=%0d", n), int'(busy), eb);
    endtask

    initial begin
        logic [3:0] prev;
        int cnt;
        int p;
        int lv;

        tbl[0] = '{leds: 4'b1010, exp_out: 4'b1010, exp_busy: 1'b0};
        tbl[1] = '{leds: 4'b0101, exp_out: 4'b0101, exp_busy: 1'b0};
        tbl[2] = '{leds: 4'b1111, exp_out: 4'b1111, exp_busy: 1'b0};
        tbl[3] = '{leds: 4'b0000, exp_out: 4'b0000, exp_busy: 1'b0};
        tbl[4] = '{leds: 4'b0011, exp_out: 4'b0011, exp_busy: 1'b0};
        tbl[5] = '{leds: 4'b1000, exp_out: 4'b1000, exp_busy: 1'b0};

        rst       = 1'b1;
        leds_in   = 4'hF;
        fade_en   = 1'b1;
        rst_b     = 1'b1;
        leds_in_b = 4'b0001;
        fade_en_b = 1'b1;

        // Reset held for two edges with all inputs active.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("reset leds_out %0d", i), int'(leds_out), 0);
            chk($sformatf("reset busy %0d", i), int'(busy), 0);
        end
        rst     = 1'b0;
        leds_in = 4'b0001;

        // Fade up, down, reversal at level 7, full fade down, ramp to 9.
        for (int n = 1; n <= 158; n++) begin
            tick();
            check_cycle(n);
            leds_in = {3'b000, din(n) != 0};
        end

        // Reset mid-ramp at level 9, then the ramp restarts from 0.
        rst = 1'b1;
        tick();
        chk("midramp reset leds_out", int'(leds_out), 0);
        chk("midramp reset busy", int'(busy), 0);
        rst = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            check_cycle(n);
        end

        // Fading disabled mid-ramp: level snaps to full.
        fade_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("snap leds_out", int'(leds_out), 1);
        chk("snap busy", int'(busy), 0);

        // Pass-through vectors: exactly three cycles of latency.
        prev = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            leds_in = tbl[k].leds;
            tick();
            tick();
            chk($sformatf("pt early leds_out v%0d", k), int'(leds_out), int'(prev));
            chk($sformatf("pt early busy v%0d", k), int'(busy), (tbl[k].leds != prev) ? 1 : 0);
            tick();
            chk($sformatf("pt leds_out v%0d", k), int'(leds_out), int'(tbl[k].exp_out));
            chk($sformatf("pt busy v%0d", k), int'(busy), int'(tbl[k].exp_busy));
            tick();
            tick();
            chk($sformatf("pt hold leds_out v%0d", k), int'(leds_out), int'(tbl[k].exp_out));
            chk($sformatf("pt hold busy v%0d", k), int'(busy), 0);
            prev = tbl[k].exp_out;
        end

        // Duty measurement: each level holds for 64 cycles; count highs over
        // the second aligned 16-cycle window of each level.
        tick();
        tick();
        rst_b = 1'b0;
        cnt   = 0;
        for (int n = 1; n <= 1008; n++) begin
            tick();
            p = (n - 1) % 64;
            if (p >= 16 && p <= 31) cnt += int'(leds_out_b[0]);
            if (p == 31) begin
                lv = (n - 1) / 64;
                chk($sformatf("duty level %0d", lv), cnt, (lv == 15) ? 16 : lv);
                chk($sformatf("duty upper bits level %0d", lv), int'(leds_out_b[3:1]), 0);
                cnt = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
